active_sweep_engine: RTL and testbench

// Parametrised active-path ACE master engine, successor to the single-line active FSM.

---
 rtl/active_sweep_engine_pkg.sv | 12 +
 rtl/active_sweep_engine_line_buf.sv | 41 ++++
 rtl/active_sweep_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_active_sweep_engine.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/active_sweep_engine_pkg.sv
// active_sweep_engine_pkg: mode codes, ACE response codes and sweep FSM state encoding
package active_sweep_engine_pkg;
    localparam logic [1:0] MODE_READ   = 2'd0;
    localparam logic [1:0] MODE_WRITE  = 2'd1;
    localparam logic [1:0] MODE_RMW    = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    typedef enum logic [4:0] {
        S_IDLE, S_AR, S_R, S_RACK, S_MOD, S_AW, S_W, S_B, S_WACK, S_NEXT, S_DONE, S_ERR
    } state_t;
endpackage

// File: rtl/active_sweep_engine_line_buf.sv
// active_line_buf: BEATS x DATA_W line buffer with per-beat write, whole-line XOR and beat read mux
//   clk, rst      clock, synchronous active-high reset (clears the line)
//   wr_en/wr_idx/wr_data   store one beat
//   xor_en/mask   line ^= mask in one cycle (takes priority over a beat write)
//   rd_idx/rd_data         combinational beat read
//   line          whole buffer, beat 0 in the low bits
module active_line_buf #(
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    localparam int IW    = $clog2(BEATS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IW-1:0]             wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      xor_en,
    input  logic [BEATS*DATA_W-1:0]   mask,
    input  logic [IW-1:0]             rd_idx,
    output logic [DATA_W-1:0]         rd_data,
    output logic [BEATS*DATA_W-1:0]   line
);
    logic [DATA_W-1:0] mem [BEATS];

    always_ff @(posedge clk) begin
        for (int k = 0; k < BEATS; k++) begin
            if (rst)
                mem[k] <= '0;
            else if (xor_en)
                mem[k] <= mem[k] ^ mask[k*DATA_W +: DATA_W];
            else if (wr_en && wr_idx == IW'(k))
                mem[k] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line[g*DATA_W +: DATA_W] = mem[g];
    end
endmodule

// File: rtl/active_sweep_engine.sv
// active_sweep_engine: ACE master sweeping N cache lines with ReadOnce / WriteUnique / read-XOR-write
//   ace_aclk, ace_areset            clock, synchronous active-high reset
//   i_start/i_abort/i_mode          control (start pulse, abort level sampled at line boundary)
//   i_base_addr/i_num_lines/i_timeout/i_cache_line/i_mask   run parameters and data
//   AR/R/AW/W/B                     ACE master channels
//   o_rack/o_wack                   per-line read / write completion pulses
//   o_cache_line                    last line read (post-mask in RMW)
//   o_busy/o_done/o_error/o_aborted/o_lines_done   run status
module active_sweep_engine
    import active_sweep_engine_pkg::*;
#(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int C_LINE_BYTES     = 64,
    parameter int C_CNT_WIDTH      = 16
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [1:0]                    i_mode,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [C_CNT_WIDTH-1:0]        i_num_lines,
    input  logic [C_CNT_WIDTH-1:0]        i_timeout,
    input  logic [C_LINE_BYTES*8-1:0]     i_cache_line,
    input  logic [C_LINE_BYTES*8-1:0]     i_mask,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_araddr,
    output logic                          o_arvalid,
    output logic [7:0]                    o_arlen,
    input  logic                          i_arready,
    input  logic                          i_rvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_rdata,
    input  logic                          i_rlast,
    input  logic [1:0]                    i_rresp,
    output logic                          o_rready,
    output logic                          o_rack,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_awaddr,
    output logic                          o_awvalid,
    output logic [7:0]                    o_awlen,
    input  logic                          i_awready,
    output logic [C_ACE_DATA_WIDTH-1:0]   o_wdata,
    output logic                          o_wvalid,
    output logic                          o_wlast,
    input  logic                          i_wready,
    input  logic                          i_bvalid,
    input  logic [1:0]                    i_bresp,
    output logic                          o_bready,
    output logic                          o_wack,
    output logic [C_LINE_BYTES*8-1:0]     o_cache_line,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    output logic                          o_aborted,
    output logic [C_CNT_WIDTH-1:0]        o_lines_done
);
    localparam int BEATS = C_LINE_BYTES * 8 / C_ACE_DATA_WIDTH;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [C_ACE_ADDR_WIDTH-1:0] LINE_MASK = C_ACE_ADDR_WIDTH'(C_LINE_BYTES - 1);
    localparam logic [C_ACE_ADDR_WIDTH-1:0] LINE_STEP = C_ACE_ADDR_WIDTH'(C_LINE_BYTES);

    state_t                        state;
    logic                          is_write;
    logic                          is_rmw;
    logic [C_ACE_ADDR_WIDTH-1:0]   line_addr;
    logic [C_ACE_ADDR_WIDTH-1:0]   base;
    logic [C_ACE_ADDR_WIDTH-1:0]   next_addr;
    logic [C_CNT_WIDTH-1:0]        num;
    logic [C_CNT_WIDTH-1:0]        tmo;
    logic [C_CNT_WIDTH-1:0]        tmo_cnt;
    logic [BW-1:0]                 beat;
    logic [C_ACE_DATA_WIDTH-1:0]   buf_rd;
    logic                          r_hs;
    logic                          hs;
    logic                          waiting;
    logic                          timed_out;

    assign base      = i_base_addr & ~LINE_MASK;
    assign next_addr = line_addr + LINE_STEP;
    assign o_araddr  = line_addr;
    assign o_awaddr  = line_addr;
    assign o_arlen   = 8'(BEATS - 1);
    assign o_awlen   = 8'(BEATS - 1);
    assign o_wlast   = o_wvalid && beat == LAST_BEAT;
    assign o_wdata   = is_write ? i_cache_line[beat*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH] : buf_rd;

    // Each valid/ready register is only ever high in its own phase, so no state qualifier is needed.
    assign r_hs      = o_rready && i_rvalid;
    assign hs        = (o_arvalid && i_arready) || r_hs || (o_awvalid && i_awready) ||
                       (o_wvalid && i_wready) || (o_bready && i_bvalid);
    assign waiting   = state inside {S_AR, S_R, S_AW, S_W, S_B};
    // tmo_cnt counts idle cycles in a waiting phase; it is zero on phase entry and after every beat.
    assign timed_out = waiting && !hs && tmo != '0 && tmo_cnt == tmo - 1'b1;

    active_line_buf #(
        .DATA_W (C_ACE_DATA_WIDTH),
        .BEATS  (BEATS)
    ) u_line_buf (
        .clk     (ace_aclk),
        .rst     (ace_areset),
        .wr_en   (r_hs),
        .wr_idx  (beat),
        .wr_data (i_rdata),
        .xor_en  (state == S_MOD),
        .mask    (i_mask),
        .rd_idx  (beat),
        .rd_data (buf_rd),
        .line    (o_cache_line)
    );

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            state        <= S_IDLE;
            is_write     <= 1'b0;
            is_rmw       <= 1'b0;
            line_addr    <= '0;
            num          <= '0;
            tmo          <= '0;
            tmo_cnt      <= '0;
            beat         <= '0;
            o_arvalid    <= 1'b0;
            o_rready     <= 1'b0;
            o_rack       <= 1'b0;
            o_awvalid    <= 1'b0;
            o_wvalid     <= 1'b0;
            o_bready     <= 1'b0;
            o_wack       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_aborted    <= 1'b0;
            o_lines_done <= '0;
        end else begin
            o_rack  <= 1'b0;
            o_wack  <= 1'b0;
            o_done  <= 1'b0;
            tmo_cnt <= (waiting && !hs) ? tmo_cnt + 1'b1 : '0;
            if (timed_out) begin
                state     <= S_ERR;
                o_error   <= 1'b1;
                o_arvalid <= 1'b0;
                o_rready  <= 1'b0;
                o_awvalid <= 1'b0;
                o_wvalid  <= 1'b0;
                o_bready  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (i_start) begin
                        is_write     <= i_mode == MODE_WRITE;
                        is_rmw       <= i_mode == MODE_RMW;
                        line_addr    <= base;
                        num          <= i_num_lines;
                        tmo          <= i_timeout;
                        o_error      <= 1'b0;
                        o_aborted    <= 1'b0;
                        o_lines_done <= '0;
                        o_busy       <= 1'b1;
                        if (i_num_lines == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else if (i_mode == MODE_WRITE) begin
                            state     <= S_AW;
                            o_awvalid <= 1'b1;
                        end else begin
                            state     <= S_AR;
                            o_arvalid <= 1'b1;
                        end
                    end
                    S_AR: if (i_arready) begin
                        state     <= S_R;
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        beat      <= '0;
                    end
                    S_R: if (i_rvalid) begin
                        // rlast must coincide exactly with the final beat
                        if (i_rresp != RESP_OKAY || i_rlast != (beat == LAST_BEAT)) begin
                            state    <= S_ERR;
                            o_error  <= 1'b1;
                            o_rready <= 1'b0;
                        end else if (beat == LAST_BEAT) begin
                            state    <= S_RACK;
                            o_rready <= 1'b0;
                            o_rack   <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    S_RACK: state <= is_rmw ? S_MOD : S_NEXT;
                    S_MOD: begin
                        state     <= S_AW;
                        o_awvalid <= 1'b1;
                    end
                    S_AW: if (i_awready) begin
                        state     <= S_W;
                        o_awvalid <= 1'b0;
                        o_wvalid  <= 1'b1;
                        beat      <= '0;
                    end
                    S_W: if (i_wready) begin
                        if (beat == LAST_BEAT) begin
                            state    <= S_B;
                            o_wvalid <= 1'b0;
                            o_bready <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    S_B: if (i_bvalid) begin
                        o_bready <= 1'b0;
                        if (i_bresp != RESP_OKAY) begin
                            state   <= S_ERR;
                            o_error <= 1'b1;
                        end else begin
                            state  <= S_WACK;
                            o_wack <= 1'b1;
                        end
                    end
                    S_WACK: state <= S_NEXT;
                    S_NEXT: begin
                        o_lines_done <= o_lines_done + 1'b1;
                        line_addr    <= next_addr;
                        if (o_lines_done + 1'b1 == num || i_abort) begin
                            state     <= S_DONE;
                            o_done    <= 1'b1;
                            o_aborted <= i_abort;
                        end else if (is_write) begin
                            state     <= S_AW;
                            o_awvalid <= 1'b1;
                        end else begin
                            state     <= S_AR;
                            o_arvalid <= 1'b1;
                        end
                    end
                    S_ERR: begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_active_sweep_engine.sv
// tb_active_sweep_engine: scoreboard bench with an ACE slave model and directed sweep scenarios
module tb_active_sweep_engine;
    logic          ace_aclk;
    logic          ace_areset;
    logic          i_start;
    logic          i_abort;
    logic [1:0]    i_mode;
    logic [43:0]   i_base_addr;
    logic [15:0]   i_num_lines;
    logic [15:0]   i_timeout;
    logic [511:0]  i_cache_line;
    logic [511:0]  i_mask;
    logic [43:0]   o_araddr;
    logic          o_arvalid;
    logic [7:0]    o_arlen;
    logic          i_arready;
    logic          i_rvalid;
    logic [127:0]  i_rdata;
    logic          i_rlast;
    logic [1:0]    i_rresp;
    logic          o_rready;
    logic          o_rack;
    logic [43:0]   o_awaddr;
    logic          o_awvalid;
    logic [7:0]    o_awlen;
    logic          i_awready;
    logic [127:0]  o_wdata;
    logic          o_wvalid;
    logic          o_wlast;
    logic          i_wready;
    logic          i_bvalid;
    logic [1:0]    i_bresp;
    logic          o_bready;
    logic          o_wack;
    logic [511:0]  o_cache_line;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic          o_aborted;
    logic [15:0]   o_lines_done;

    active_sweep_engine dut (
        .ace_aclk(ace_aclk), .ace_areset(ace_areset), .i_start(i_start), .i_abort(i_abort),
        .i_mode(i_mode), .i_base_addr(i_base_addr), .i_num_lines(i_num_lines), .i_timeout(i_timeout),
        .i_cache_line(i_cache_line), .i_mask(i_mask),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .o_arlen(o_arlen), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rresp(i_rresp),
        .o_rready(o_rready), .o_rack(o_rack),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .o_awlen(o_awlen), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wvalid(o_wvalid), .o_wlast(o_wlast), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready), .o_wack(o_wack),
        .o_cache_line(o_cache_line), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_aborted(o_aborted), .o_lines_done(o_lines_done)
    );

    initial ace_aclk = 1'b0;
    always #5 ace_aclk = ~ace_aclk;

    int n_vec = 0;
    int n_err = 0;

    // expectation queues filled by the stimulus, drained by the monitor
    logic [43:0]  exp_ar[$];
    logic [43:0]  exp_aw[$];
    logic [128:0] exp_w[$];
    logic [33:0]  exp_done[$];

    // slave configuration, written by the stimulus
    logic         cfg_arready = 1'b1;
    logic         cfg_awready = 1'b1;
    logic         cfg_wready  = 1'b1;
    logic         cfg_wstall  = 1'b0;
    logic [1:0]   cfg_bresp   = 2'd0;
    logic [511:0] cfg_rline   = '0;

    // handshake flags sampled just before each rising edge by the monitor
    logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, wl_hs = 0, b_hs = 0;
    int   ar_cnt = 0, aw_cnt = 0, done_cnt = 0;
    logic [7:0] rack_n = 0, wack_n = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT event seen with no expectation queued", nm);
    endtask

    // monitor
    initial forever begin
        @(negedge ace_aclk);
        #4;
        ar_hs = o_arvalid && i_arready && !ace_areset;
        r_hs  = o_rready && i_rvalid && !ace_areset;
        aw_hs = o_awvalid && i_awready && !ace_areset;
        w_hs  = o_wvalid && i_wready && !ace_areset;
        wl_hs = w_hs && o_wlast;
        b_hs  = o_bready && i_bvalid && !ace_areset;
        if (ar_hs) begin
            ar_cnt++;
            if (exp_ar.size() == 0) unexp("ar");
            else chk("araddr", 512'(o_araddr), 512'(exp_ar.pop_front()));
            chk("arlen", 512'(o_arlen), 512'(3));
        end
        if (aw_hs) begin
            aw_cnt++;
            if (exp_aw.size() == 0) unexp("aw");
            else chk("awaddr", 512'(o_awaddr), 512'(exp_aw.pop_front()));
            chk("awlen", 512'(o_awlen), 512'(3));
        end
        if (w_hs) begin
            if (exp_w.size() == 0) unexp("w");
            else chk("wlast_wdata", 512'({o_wlast, o_wdata}), 512'(exp_w.pop_front()));
        end
        if (o_rack && !ace_areset) rack_n++;
        if (o_wack && !ace_areset) wack_n++;
        if (o_done && !ace_areset) begin
            done_cnt++;
            if (exp_done.size() == 0) unexp("done");
            else chk("done_lines_err_abt_rack_wack",
                     512'({o_lines_done, o_error, o_aborted, rack_n, wack_n}), 512'(exp_done.pop_front()));
            rack_n = 0;
            wack_n = 0;
        end
    end

    // ACE slave model
    initial begin
        int         r_left;
        logic [1:0] r_beat;
        logic [1:0] w_cnt;
        logic       stalled;
        logic       b_pend;
        r_left = 0; r_beat = 0; w_cnt = 0; stalled = 0; b_pend = 0;
        i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rlast = 0; i_rresp = 0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        forever begin
            @(negedge ace_aclk);
            if (ace_areset) begin
                r_left = 0; r_beat = 0; w_cnt = 0; stalled = 0; b_pend = 0;
            end else begin
                if (ar_hs) begin r_left = 4; r_beat = 0; end
                if (r_hs) begin r_left--; r_beat++; end
                if (w_hs) begin w_cnt++; stalled = 0; end
                if (wl_hs) b_pend = 1;
                if (b_hs) b_pend = 0;
            end
            i_arready = cfg_arready;
            i_awready = cfg_awready;
            i_rvalid  = r_left > 0;
            i_rdata   = cfg_rline[r_beat*128 +: 128];
            i_rlast   = r_left > 0 && r_beat == 2'd3;
            i_rresp   = 2'd0;
            if (!cfg_wready) i_wready = 0;
            else if (cfg_wstall && o_wvalid && (w_cnt == 2'd1 || w_cnt == 2'd3) && !stalled) begin
                i_wready = 0;
                stalled  = 1;
            end else i_wready = 1;
            i_bvalid = b_pend;
            i_bresp  = cfg_bresp;
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [43:0] b, input logic [15:0] n, input logic [15:0] t);
        @(negedge ace_aclk);
        i_mode = m; i_base_addr = b; i_num_lines = n; i_timeout = t; i_start = 1;
        @(negedge ace_aclk);
        i_start = 0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int c = 0;
        while (done_cnt == d0 && c < 300) begin
            @(negedge ace_aclk);
            c++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no done pulse within 300 cycles", nm);
        end
        @(negedge ace_aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // stimulus
    initial begin
        logic [511:0] line_a, line_w;
        int d0, a0, n;
        for (int k = 0; k < 4; k++) line_a[k*128 +: 128] = {16{8'hA0 + 8'(k)}};
        line_w = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
        ace_areset = 1; i_start = 0; i_abort = 0; i_mode = 0; i_base_addr = '0;
        i_num_lines = '0; i_timeout = '0; i_cache_line = '0; i_mask = '0;
        repeat (3) @(negedge ace_aclk);
        chk("reset_valids_readies", 512'({o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}), 512'(0));
        chk("reset_status", 512'({o_busy, o_done, o_error, o_aborted, o_rack, o_wack}), 512'(0));
        chk("reset_lines_done", 512'(o_lines_done), 512'(0));
        chk("reset_cache_line", o_cache_line, 512'(0));
        ace_areset = 0;

        // READ two lines from 0x1000_0040
        cfg_rline = line_a;
        exp_ar.push_back(44'h0_1000_0040);
        exp_ar.push_back(44'h0_1000_0080);
        exp_done.push_back({16'd2, 1'b0, 1'b0, 8'd2, 8'd0});
        d0 = done_cnt;
        start_run(2'd0, 44'h0_1000_0040, 16'd2, 16'd0);
        chk("start_to_arvalid_latency", 512'({o_arvalid, o_busy}), 512'(2'b11));
        wait_done("read2", d0);
        chk("read_cache_line", o_cache_line, line_a);

        // WRITE one line, unaligned base, wready stalls beats 1 and 3
        cfg_wstall = 1;
        i_cache_line = line_w;
        exp_aw.push_back(44'h2000);
        exp_w.push_back({1'b0, {16{8'h11}}});
        exp_w.push_back({1'b0, {16{8'h22}}});
        exp_w.push_back({1'b0, {16{8'h33}}});
        exp_w.push_back({1'b1, {16{8'h44}}});
        exp_done.push_back({16'd1, 1'b0, 1'b0, 8'd0, 8'd1});
        d0 = done_cnt;
        start_run(2'd1, 44'h2013, 16'd1, 16'd0);
        wait_done("write1", d0);
        cfg_wstall = 0;

        // RMW: read 0xAA.., mask 0xFF.. -> write 0x55..
        cfg_rline = {64{8'hAA}};
        i_mask = {64{8'hFF}};
        i_cache_line = '0;
        exp_ar.push_back(44'h3000);
        exp_aw.push_back(44'h3000);
        for (int k = 0; k < 4; k++) exp_w.push_back({k == 3, {16{8'h55}}});
        exp_done.push_back({16'd1, 1'b0, 1'b0, 8'd1, 8'd1});
        d0 = done_cnt;
        start_run(2'd2, 44'h3000, 16'd1, 16'd0);
        wait_done("rmw1", d0);
        chk("rmw_cache_line", o_cache_line, {64{8'h55}});

        // READ four lines, abort raised during the second line's R phase
        cfg_rline = line_a;
        exp_ar.push_back(44'h4000);
        exp_ar.push_back(44'h4040);
        exp_done.push_back({16'd2, 1'b0, 1'b1, 8'd2, 8'd0});
        d0 = done_cnt;
        a0 = ar_cnt;
        start_run(2'd0, 44'h4000, 16'd4, 16'd0);
        for (int c = 0; c < 100 && ar_cnt < a0 + 2; c++) @(negedge ace_aclk);
        i_abort = 1;
        wait_done("abort", d0);
        i_abort = 0;

        // AR timeout of 8 cycles
        cfg_arready = 0;
        exp_done.push_back({16'd0, 1'b1, 1'b0, 8'd0, 8'd0});
        d0 = done_cnt;
        start_run(2'd0, 44'h5000, 16'd1, 16'd8);
        n = 0;
        for (int c = 0; c < 60 && done_cnt == d0; c++) begin
            if (o_arvalid) n++;
            @(negedge ace_aclk);
        end
        wait_done("timeout", d0);
        chk("timeout_arvalid_cycles", 512'(n), 512'(8));
        chk("timeout_arvalid_low_error_sticky", 512'({o_arvalid, o_error}), 512'(2'b01));
        cfg_arready = 1;

        // SLVERR on the first line's B response
        cfg_bresp = 2'd2;
        i_cache_line = line_w;
        exp_aw.push_back(44'h6000);
        exp_w.push_back({1'b0, {16{8'h11}}});
        exp_w.push_back({1'b0, {16{8'h22}}});
        exp_w.push_back({1'b0, {16{8'h33}}});
        exp_w.push_back({1'b1, {16{8'h44}}});
        exp_done.push_back({16'd0, 1'b1, 1'b0, 8'd0, 8'd0});
        d0 = done_cnt;
        start_run(2'd1, 44'h6000, 16'd2, 16'd0);
        wait_done("slverr", d0);
        chk("slverr_error_sticky", 512'({o_error, o_busy}), 512'(2'b10));
        cfg_bresp = 2'd0;

        // num=0 no-op with reserved mode; start clears the sticky error
        exp_done.push_back({16'd0, 1'b0, 1'b0, 8'd0, 8'd0});
        d0 = done_cnt;
        start_run(2'd3, 44'h8000, 16'd0, 16'd0);
        chk("start_clears_error", 512'(o_error), 512'(0));
        wait_done("noop", d0);

        // reset while W is stalled
        cfg_wready = 0;
        exp_aw.push_back(44'h7000);
        a0 = aw_cnt;
        start_run(2'd1, 44'h7000, 16'd1, 16'd0);
        for (int c = 0; c < 50 && aw_cnt == a0; c++) @(negedge ace_aclk);
        chk("w_phase_wvalid_before_reset", 512'(o_wvalid), 512'(1));
        @(negedge ace_aclk);
        ace_areset = 1;
        @(negedge ace_aclk);
        chk("reset_mid_w", 512'({o_wvalid, o_awvalid, o_busy, o_bready}), 512'(0));
        chk("reset_mid_w_lines_done", 512'(o_lines_done), 512'(0));
        ace_areset = 0;
        cfg_wready = 1;
        repeat (3) @(negedge ace_aclk);

        chk("leftover_expectations", 512'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
